truth_table_sweeper: RTL and testbench

- Parametrised, clocked, self-checking exhaustive stimulus engine for combinational blocks with N single-bit inputs and one output.
- Drives every input vector 0..2^N-1 in ascending order and holds each one for a programmable dwell. Samples the DUT output and compares it against a golden truth table.
- Reports mismatch count, first failing vector and pass/fail.
- Sits beside the DUT in unit benches and in on-chip BIST wrappers for small logic cones.

---
 rtl/tt_sweep_pkg.sv | 29 ++
 rtl/tt_dwell_timer.sv | 46 ++++
 rtl/truth_table_sweeper.sv | 136 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tt_sweep_pkg
//  Description : Shared types and helpers for the truth-table sweeper:
//                FSM state encoding, vector-count helper and a saturating
//                increment used by the mismatch counter.
//  Revision    : 1.0  initial release
// ============================================================================
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } tt_state_e;

  // Number of distinct input vectors for an n-input combinational block.
  function automatic int unsigned vec_count(input int unsigned n);
    return 32'd1 << n;
  endfunction

  // Increment that sticks once max_v is reached.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tt_dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tt_dwell_timer
//  Description : Dwell counter. Counts while enabled, wraps to zero on the
//                cycle it reaches DWELL-1 and flags that cycle on tc_o.
//  Ports       : clk, rst_n   - clock / async active-low reset
//                clr_i        - synchronous clear to zero (wins over en_i)
//                en_i         - count enable
//                tc_o         - terminal count (count == DWELL-1)
//  Revision    : 1.0  initial release
// ============================================================================
module tt_dwell_timer #(
  parameter int unsigned DWELL = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      // Self-wrapping, so back-to-back vectors need no explicit clear.
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweeper
//  Description : Exhaustive stimulus engine for an N-input, 1-output
//                combinational block. Drives vectors 0..2^N-1, holds each
//                for DWELL cycles, compares the DUT output against EXPECTED
//                on the last dwell cycle and records the results.
//  Ports       : clk, rst_n          - clock / async active-low reset
//                start_i, abort_i    - begin sweep / return to idle
//                loop_mode_i         - continuous sweeping (latched at start)
//                stim_o              - vector to the DUT (MSB = first input)
//                dut_f_i             - DUT output
//                busy_o, done_o      - APPLY / DONE state flags
//                pass_o              - done with zero mismatches
//                err_count_o         - saturating mismatch count
//                first_fail_vec_o    - first mismatching vector
//                first_fail_valid_o  - first_fail_vec_o is valid
//  Revision    : 1.0  initial release
// ============================================================================
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int unsigned                      N_INPUTS = 3,
  parameter logic [vec_count(N_INPUTS)-1:0]   EXPECTED = 8'b1110_1000,
  parameter int unsigned                      DWELL    = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                loop_mode_i,
  output logic [N_INPUTS-1:0] stim_o,
  input  logic                dut_f_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [N_INPUTS:0]   err_count_o,
  output logic [N_INPUTS-1:0] first_fail_vec_o,
  output logic                first_fail_valid_o
);

  localparam int unsigned   ERR_W   = N_INPUTS + 1;
  localparam logic [ERR_W-1:0] C_ERR_MAX = '1;

  tt_state_e           state_q, state_d;
  logic [N_INPUTS-1:0] idx_q, idx_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [N_INPUTS-1:0] ffv_q, ffv_d;
  logic                ffvalid_q, ffvalid_d;
  logic                loop_q, loop_d;

  logic w_tc;
  logic w_timer_clr;
  logic w_last_dwell;

  tt_dwell_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (w_timer_clr),
    .en_i  (busy_o),
    .tc_o  (w_tc)
  );

  assign busy_o             = (state_q == APPLY);
  assign done_o             = (state_q == DONE);
  assign pass_o             = done_o && (err_q == '0);
  assign stim_o             = idx_q;
  assign err_count_o        = err_q;
  assign first_fail_vec_o   = ffv_q;
  assign first_fail_valid_o = ffvalid_q;
  assign w_last_dwell       = busy_o && w_tc;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_d       = err_q;
    ffv_d       = ffv_q;
    ffvalid_d   = ffvalid_q;
    loop_d      = loop_q;
    w_timer_clr = 1'b0;

    // Compare and advance on the final dwell cycle. This is evaluated ahead
    // of abort so a compare landing on the abort edge is still recorded.
    if (w_last_dwell) begin
      if (dut_f_i != EXPECTED[idx_q]) begin
        err_d = ERR_W'(sat_inc(32'(err_q), 32'(C_ERR_MAX)));
        if (!ffvalid_q) begin
          ffv_d     = idx_q;
          ffvalid_d = 1'b1;
        end
      end
      if (idx_q == '1) begin
        if (loop_q) idx_d   = '0;
        else        state_d = DONE;   // stim holds the last vector
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (abort_i) begin
      state_d     = IDLE;
      idx_d       = '0;
      w_timer_clr = 1'b1;
    end else if (start_i && (state_q != APPLY)) begin
      state_d     = APPLY;
      idx_d       = '0;
      err_d       = '0;
      ffv_d       = '0;
      ffvalid_d   = 1'b0;
      loop_d      = loop_mode_i;
      w_timer_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      loop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      loop_q    <= loop_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_sweeper
//  Description : Bench for truth_table_sweeper (N=3, EXPECTED=8'hE8) with a
//                majority-gate DUT model that can be faulted. A second
//                instance runs with DWELL=1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, loop_mode;
  logic [2:0] stim;
  logic       dut_f;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] ffv;
  logic       ffvalid;

  logic       start1;
  logic [2:0] stim1;
  logic       dut_f1;
  logic       busy1, done1, pass1;
  logic [3:0] err1;
  logic [2:0] ffv1;
  logic       ffvalid1;

  int mode;       // 0 good, 1 stuck-0, 2 inverted, 3 wrong only at vector 7
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic maj(input logic [2:0] s);
    return (s[2] & s[1]) | (s[2] & s[0]) | (s[1] & s[0]);
  endfunction

  always_comb begin
    dut_f = maj(stim);
    case (mode)
      1:       dut_f = 1'b0;
      2:       dut_f = ~maj(stim);
      3:       dut_f = maj(stim) ^ (stim == 3'd7);
      default: dut_f = maj(stim);
    endcase
  end
  assign dut_f1 = maj(stim1);

  truth_table_sweeper #(.N_INPUTS(3), .EXPECTED(8'hE8), .DWELL(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .loop_mode_i(loop_mode), .stim_o(stim), .dut_f_i(dut_f),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err_count),
    .first_fail_vec_o(ffv), .first_fail_valid_o(ffvalid)
  );

  truth_table_sweeper #(.N_INPUTS(3), .EXPECTED(8'hE8), .DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(1'b0),
    .loop_mode_i(1'b0), .stim_o(stim1), .dut_f_i(dut_f1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1),
    .first_fail_vec_o(ffv1), .first_fail_valid_o(ffvalid1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse start for one edge; returns just after the first APPLY edge.
  task automatic do_start(input logic lp);
    start = 1'b1; loop_mode = lp;
    tick();
    start = 1'b0; loop_mode = 1'b0;
  endtask

  typedef struct {
    int   mode;
    int   exp_err;
    int   exp_ffv;
    logic exp_ffvalid;
    logic exp_pass;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{mode: 0, exp_err: 0, exp_ffv: 0, exp_ffvalid: 1'b0, exp_pass: 1'b1};
    tbl[1] = '{mode: 1, exp_err: 4, exp_ffv: 3, exp_ffvalid: 1'b1, exp_pass: 1'b0};
    tbl[2] = '{mode: 2, exp_err: 8, exp_ffv: 0, exp_ffvalid: 1'b1, exp_pass: 1'b0};
    tbl[3] = '{mode: 0, exp_err: 0, exp_ffv: 0, exp_ffvalid: 1'b0, exp_pass: 1'b1};

    mode = 0; start = 0; abort = 0; loop_mode = 0; start1 = 0;
    rst_n = 1'b0;
    #12;
    chk("rst_stim", stim, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ffvalid", ffvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Full single sweeps with different DUT behaviours.
    for (int r = 0; r < 4; r++) begin
      mode = tbl[r].mode;
      do_start(1'b0);
      chk("first_apply_err_clear", err_count, 0);
      chk("first_apply_ffvalid_clear", ffvalid, 0);
      chk("first_apply_done_clear", done, 0);
      for (int c = 0; c < 16; c++) begin
        chk("sweep_stim", stim, c / 2);
        chk("sweep_busy", busy, 1);
        if (c < 15) tick();
      end
      tick();
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_pass", pass, tbl[r].exp_pass);
      chk("end_err", err_count, tbl[r].exp_err);
      chk("end_ffvalid", ffvalid, tbl[r].exp_ffvalid);
      if (tbl[r].exp_ffvalid) chk("end_ffv", ffv, tbl[r].exp_ffv);
      chk("end_stim_hold", stim, 7);
      tick();
      chk("done_level", done, 1);
    end

    // Continuous mode: one error per sweep, abort on the edge of the third
    // sweep's final compare.
    mode = 3;
    do_start(1'b1);
    for (int c = 1; c < 48; c++) begin
      tick();
      if (c == 16) begin
        chk("loop_wrap_stim", stim, 0);
        chk("loop_busy", busy, 1);
        chk("loop_err1", err_count, 1);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("loop_abort_busy", busy, 0);
    chk("loop_abort_done", done, 0);
    chk("loop_abort_stim", stim, 0);
    chk("loop_abort_err", err_count, 3);
    chk("loop_abort_ffv", ffv, 7);

    // Abort while idx=5 with start in the same cycle.
    mode = 1;
    do_start(1'b0);
    for (int c = 1; c <= 10; c++) tick();
    chk("pre_abort_stim", stim, 5);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_stim", stim, 0);
    chk("abort_err_kept", err_count, 1);
    chk("abort_ffv_kept", ffv, 3);
    tick();
    chk("abort_start_ignored", busy, 0);

    // Asynchronous reset between edges at idx=4.
    mode = 1;
    do_start(1'b0);
    for (int c = 1; c <= 8; c++) tick();
    chk("pre_rst_stim", stim, 4);
    chk("pre_rst_err", err_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stim", stim, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_err", err_count, 0);
    chk("async_rst_ffvalid", ffvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    // DWELL=1 instance: one vector per cycle.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("d1_stim", stim1, c);
      if (c < 7) tick();
    end
    chk("d1_busy", busy1, 1);
    tick();
    chk("d1_done", done1, 1);
    chk("d1_pass", pass1, 1);
    chk("d1_err", err1, 0);
    chk("d1_ffvalid", ffvalid1, 0);
    chk("d1_ffv", ffv1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
